// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder cell; purely combinational, carry storage lives in the controller.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (b & ci) | (ci & a);

endmodule

// File: rtl/serial_add_ctrl.sv
// Word-level valid/ready front end for the bit-serial adder: streams operands
// LSB-first through serial_fa_bit and returns sum/cout on a second handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for in_valid; in_ready high
// ST_SHIFT | one operand bit per clock through the full-adder cell
// ST_DONE  | sum/cout presented with out_valid until out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  serial_fa_bit u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sr_d   = op_a;
          b_sr_d   = op_b;
          carry_d  = cin;
          sum_sr_d = '0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Concatenate-then-slice keeps the shift legal for WIDTH == 1.
        sum_sr_d = {fa_s, sum_sr_q} >> 1;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign sum       = sum_sr_q;
  assign cout      = carry_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 plus an 8-bit random sweep.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
  logic [7:0] op_a8, op_b8, sum8;
  logic [3:0] bit_cnt8;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
  logic [0:0] op_a1, op_b1, sum1;
  logic [0:0] bit_cnt1;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .op_a(op_a8), .op_b(op_b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8), .bit_cnt(bit_cnt8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1), .bit_cnt(bit_cnt1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    op_a8 = a; op_b8 = b; cin8 = ci; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
  endtask

  task automatic wait_out8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_out1(output int lat);
    lat = 0;
    while (!out_valid1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rexp;

    reset = 1'b0;
    in_valid8 = 0; out_ready8 = 1; op_a8 = '0; op_b8 = '0; cin8 = 0;
    in_valid1 = 0; out_ready1 = 1; op_a1 = '0; op_b1 = '0; cin1 = 0;
    tick();
    tick();
    check("rst_in_ready",  64'(in_ready8),  64'd1);
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_busy",      64'(busy8),      64'd0);
    check("rst_sum",       64'(sum8),       64'd0);
    check("rst_cout",      64'(cout8),      64'd0);
    check("rst_bit_cnt",   64'(bit_cnt8),   64'd0);
    check("rst_in_ready1", 64'(in_ready1),  64'd1);
    reset = 1'b1;
    tick();

    // FF + 01: latency WIDTH, full wrap with carry out
    accept8(8'hFF, 8'h01, 1'b0);
    check("t1_busy",     64'(busy8),     64'd1);
    check("t1_in_ready", 64'(in_ready8), 64'd0);
    check("t1_cnt0",     64'(bit_cnt8),  64'd0);
    wait_out8(lat);
    check("t1_latency",  64'(lat),       64'd8);
    check("t1_sum",      64'(sum8),      64'h00);
    check("t1_cout",     64'(cout8),     64'd1);
    check("t1_bit_cnt",  64'(bit_cnt8),  64'd8);
    tick();
    check("t1_back_idle", 64'(in_ready8),  64'd1);
    check("t1_ov_low",    64'(out_valid8), 64'd0);

    // Back-to-back ops: second accept lands WIDTH+2 edges after the first
    accept8(8'hA5, 8'h5A, 1'b1);
    op_a8 = 8'h12; op_b8 = 8'h34; cin8 = 1'b0; in_valid8 = 1'b1;
    n = 0;
    while (n < 20 && !in_ready8) begin
      tick();
      n++;
      if (n == 8) begin
        check("t2a_ov",   64'(out_valid8), 64'd1);
        check("t2a_sum",  64'(sum8),       64'h00);
        check("t2a_cout", 64'(cout8),      64'd1);
      end
    end
    check("t2_idle_edge", 64'(n), 64'd9);
    tick();
    check("t2_accept", 64'(in_ready8), 64'd0);
    in_valid8 = 1'b0;
    wait_out8(lat);
    check("t2b_latency", 64'(lat),   64'd8);
    check("t2b_sum",     64'(sum8),  64'h46);
    check("t2b_cout",    64'(cout8), 64'd0);
    tick();

    // Backpressure in DONE with in_valid high and moving operands
    out_ready8 = 1'b0;
    accept8(8'hC8, 8'h64, 1'b1);
    in_valid8 = 1'b1;
    wait_out8(lat);
    check("t3_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      op_a8 = 8'(i * 17 + 3); op_b8 = 8'(i * 29 + 7); cin8 = i[0];
      tick();
      check("t3_ov_hold", 64'(out_valid8), 64'd1);
      check("t3_in_rdy",  64'(in_ready8),  64'd0);
      check("t3_sum",     64'(sum8),       64'h2D);
      check("t3_cout",    64'(cout8),      64'd1);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    check("t3_released", 64'(out_valid8), 64'd0);
    check("t3_idle",     64'(in_ready8),  64'd1);
    check("t3_sum_kept", 64'(sum8),       64'h2D);

    // Reset during the third SHIFT cycle, then reset beats a pending handshake
    accept8(8'h55, 8'h0F, 1'b0);
    tick();
    tick();
    check("t4_cnt_mid", 64'(bit_cnt8), 64'd2);
    reset = 1'b0;
    op_a8 = 8'h03; op_b8 = 8'h04; cin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    check("t4_in_ready", 64'(in_ready8),  64'd1);
    check("t4_ov",       64'(out_valid8), 64'd0);
    check("t4_busy",     64'(busy8),      64'd0);
    check("t4_sum",      64'(sum8),       64'd0);
    check("t4_cout",     64'(cout8),      64'd0);
    check("t4_cnt",      64'(bit_cnt8),   64'd0);
    tick();
    check("t4_rst_wins", 64'(busy8), 64'd0);
    reset = 1'b1;
    tick();
    check("t4_accept", 64'(busy8), 64'd1);
    in_valid8 = 1'b0;
    wait_out8(lat);
    check("t4_latency", 64'(lat),   64'd8);
    check("t4_sum7",    64'(sum8),  64'h07);
    check("t4_cout7",   64'(cout8), 64'd0);
    tick();

    // WIDTH=1 instance
    op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("w1_busy", 64'(busy1), 64'd1);
    wait_out1(lat);
    check("w1_latency", 64'(lat),      64'd1);
    check("w1_sum",     64'(sum1),     64'd1);
    check("w1_cout",    64'(cout1),    64'd1);
    check("w1_cnt",     64'(bit_cnt1), 64'd1);
    tick();
    op_a1 = 1'b0; op_b1 = 1'b1; cin1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    wait_out1(lat);
    check("w1b_sum",  64'(sum1),  64'd1);
    check("w1b_cout", 64'(cout1), 64'd0);
    tick();

    // Random 8-bit operands against a plain 9-bit addition
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      accept8(ra, rb, rc);
      wait_out8(lat);
      check("rnd_sum",  64'(sum8),  64'(rexp[7:0]));
      check("rnd_cout", 64'(cout8), 64'(rexp[8]));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
